// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one external memory bus between the instruction-fetch port (i_*) and
// the data-access port (d_*). A granted request is latched into the bus
// registers and held on the bus until memory answers with ACK_n low. The
// winner then sees a one-cycle ack together with its read data. A transaction
// that sees no ACK_n for TIMEOUT busy cycles is aborted: the owner gets
// ERR_DATA plus an ack, and the sticky bus_err flag is set.
//
// Arbitration (default build): data has priority, but once fetch has lost
// STARVE_MAX consecutive contended arbitrations it is forced to win.
// Optional feature macro ARB_RR_EN: contended arbitrations alternate using a
// last-grant bit (data wins the first one after reset); no starvation counter.
//
// Parameters
//   BIT_WIDTH   address/data width
//   TIMEOUT     busy cycles without ACK_n before abort (>= 2)
//   STARVE_MAX  consecutive lost arbitrations before fetch is forced (>= 1)
//   ERR_DATA    read data returned on a timeout
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   i_req/i_addr             fetch request (held until i_ack) and address
//   i_rdata/i_ack            fetched word and one-cycle completion pulse
//   d_req/d_write/d_size     data request, 1 = store, 00 word/01 half/10 byte
//   d_addr/d_wdata           data address and store data
//   d_rdata/d_ack            load data and one-cycle completion pulse
//   MAD/MREQ/WRITE/SIZE      bus address, request, direction, access size
//   MDT_O/MDT_I              bus write data / read data
//   ACK_n                    active-low memory acknowledge
//   bus_err                  sticky timeout flag, cleared only by rst
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int                   BIT_WIDTH  = 32,
  parameter int                   TIMEOUT    = 64,
  parameter int                   STARVE_MAX = 4,
  parameter logic [BIT_WIDTH-1:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req,
  input  logic [BIT_WIDTH-1:0] i_addr,
  output logic [BIT_WIDTH-1:0] i_rdata,
  output logic                 i_ack,
  input  logic                 d_req,
  input  logic                 d_write,
  input  logic [1:0]           d_size,
  input  logic [BIT_WIDTH-1:0] d_addr,
  input  logic [BIT_WIDTH-1:0] d_wdata,
  output logic [BIT_WIDTH-1:0] d_rdata,
  output logic                 d_ack,
  output logic [BIT_WIDTH-1:0] MAD,
  output logic                 MREQ,
  output logic                 WRITE,
  output logic [1:0]           SIZE,
  output logic [BIT_WIDTH-1:0] MDT_O,
  input  logic [BIT_WIDTH-1:0] MDT_I,
  input  logic                 ACK_n,
  output logic                 bus_err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] I_BUSY = 2'd1;
  localparam logic [1:0] D_BUSY = 2'd2;

  localparam int            TW     = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [TW-1:0] tmo_cnt;
  logic          write_q;
  logic          grant_i;
  logic          grant_d;

  // The bus is owned exactly while the FSM is busy; WRITE is forced low in
  // IDLE while MAD/SIZE/MDT_O keep their last values.
  assign MREQ  = (state != IDLE);
  assign WRITE = write_q & MREQ;

`ifdef ARB_RR_EN
  // Set when the most recent grant went to fetch; reset to 1 so that data
  // wins the first contended arbitration.
  logic last_fetch;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      if (i_req && d_req) begin
        grant_i = ~last_fetch;
        grant_d = last_fetch;
      end else begin
        grant_d = d_req;
        grant_i = i_req;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_fetch <= 1'b1;
    end else if (grant_i) begin
      last_fetch <= 1'b1;
    end else if (grant_d) begin
      last_fetch <= 1'b0;
    end
  end
`else
  localparam int            SW    = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] S_MAX = SW'(STARVE_MAX);

  // Consecutive contended arbitrations lost by fetch, saturating at S_MAX.
  logic [SW-1:0] starve_cnt;
  logic          starved;

  assign starved = (starve_cnt == S_MAX);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      if (i_req && starved) begin
        grant_i = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end else if (i_req) begin
        grant_i = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_i) begin
      starve_cnt <= '0;
    end else if (grant_d && i_req && !starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order inside the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tmo_cnt <= '0;
      MAD     <= '0;
      SIZE    <= 2'b00;
      write_q <= 1'b0;
      MDT_O   <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      // Acks are single-cycle: they are only ever set on the completing edge,
      // and the FSM is back in IDLE on the following one.
      i_ack <= 1'b0;
      d_ack <= 1'b0;

      case (state)
        IDLE: begin
          // ACK_n is deliberately not looked at here.
          if (grant_i) begin
            state   <= I_BUSY;
            MAD     <= i_addr;
            SIZE    <= 2'b00;
            write_q <= 1'b0;
            tmo_cnt <= '0;
          end else if (grant_d) begin
            state   <= D_BUSY;
            MAD     <= d_addr;
            SIZE    <= d_size;
            write_q <= d_write;
            MDT_O   <= d_wdata;
            tmo_cnt <= '0;
          end
        end

        I_BUSY, D_BUSY: begin
          // An acknowledge on the timeout edge still counts as a normal
          // completion, so it is checked first.
          if (!ACK_n) begin
            state <= IDLE;
            if (state == I_BUSY) begin
              i_ack   <= 1'b1;
              i_rdata <= MDT_I;
            end else begin
              d_ack <= 1'b1;
              if (!write_q) begin
                d_rdata <= MDT_I;
              end
            end
          end else if (tmo_cnt == T_LAST) begin
            state   <= IDLE;
            bus_err <= 1'b1;
            if (state == I_BUSY) begin
              i_ack   <= 1'b1;
              i_rdata <= ERR_DATA;
            end else begin
              d_ack   <= 1'b1;
              d_rdata <= ERR_DATA;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
